alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameters: none; datapath width is fixed at 16 bit.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous and active-low.
REQ-004 start  in  1  command request; sampled only in IDLE.
REQ-005 cmd  in  3  command: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL; all other codes are illegal.
REQ-006 op_a  in  16  first operand, multiplicand for MUL.
REQ-007 op_b  in  16  second operand, multiplier for MUL.
REQ-008 busy  out  1  high while a command executes.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  last accepted command was illegal.
REQ-011 result  out  16  registered result of the last legal command.
REQ-012 flags  out  4  registered status {V,N,Z,C} (bit3..bit0).
REQ-013 alu_a, alu_b  out  16  operands to the external combinational 16-bit ALU.
REQ-014 alu_op  out  3  ALUOp to the ALU; uses the same codes as cmd for 000/001/010/110.
REQ-015 alu_result  in  16  ALU result; sampled in the same cycle it is driven.
REQ-016 alu_sreg  in  4  ALU status {V,N,Z,C}.

Function
REQ-017 States: IDLE, EXEC, MUL, DONE.
REQ-018 IDLE with start=1 and a legal cmd (cycle T) SHALL latch op_a, op_b and cmd, clear err, go to EXEC (AND/OR/ADD/SUB) or MUL, and raise busy from T+1.
REQ-019 IDLE with start=1 and an illegal cmd SHALL go to DONE at T+1 with err=1; result and flags hold their values.
REQ-020 EXEC (one cycle): alu_op=latched cmd, alu_a/alu_b=latched operands; at the end of the cycle result<=alu_result, flags<=alu_sreg; next state DONE.
REQ-021 MUL init at acceptance: acc=0, mcand=op_a, mplier=op_b, lost=0, ovf=0, step=0.
REQ-022 Each MUL cycle: alu_op=010, alu_a=acc, alu_b=mcand.
REQ-023 Each MUL cycle, if mplier[0]=1: acc<=alu_result, and ovf is set if alu_sreg[0]=1 or lost=1.
REQ-024 Each MUL cycle, always: lost|=mcand[15]; mcand<=mcand<<1; mplier<=mplier>>1; step<=step+1.
REQ-025 MUL SHALL run exactly 16 cycles (T+1..T+16) with no early exit, then go to DONE with result<=acc.
REQ-026 MUL end flags: C=ovf, Z=(acc==0), N=acc[15], V=0; ovf=1 exactly when the true 32-bit product is at least 2^16.
REQ-027 DONE (one cycle): done=1, busy=0, next state IDLE; start in DONE SHALL be ignored.
REQ-028 Latency: single-cycle ops give done at T+2; MUL gives done at T+17; illegal cmd gives done at T+1.
REQ-029 start while busy SHALL be ignored; operand and cmd changes after T SHALL NOT affect the running command.
REQ-030 In IDLE and DONE: alu_op=000, alu_a=0, alu_b=0.
REQ-031 result, flags and err SHALL hold between commands until the next accepted start.

Reset
REQ-032 rst_n=0 SHALL immediately force: IDLE; busy=0, done=0, err=0; result=0, flags=0; alu_a=0, alu_b=0, alu_op=000; acc, mcand, mplier, step, lost and ovf cleared.
REQ-033 Reset during EXEC or MUL SHALL abort the command with no done pulse.
REQ-034 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 ADD op_a=16, op_b=1 -> done at T+2, result=17, flags C=0 Z=0; SUB 15-15 -> result=0, Z=1.
REQ-036 ADD 65535+1 -> result=0, C=1, Z=1; SUB 15-16 -> result=65535, flags equal alu_sreg.
REQ-037 MUL 300*200 -> busy T+1..T+16, done at T+17, result=60000, C=0.
REQ-038 MUL 256*256 -> result=0, C=1, Z=1; MUL 0xFFFF*1 -> result=65535, C=0, N=1; MUL 0*5 -> Z=1.
REQ-039 start with cmd=111 -> done at T+1, err=1, result unchanged; a start pulse during busy or DONE -> ignored, no extra done.
REQ-040 rst_n low at MUL step 8 -> busy=0 and result=0 immediately, no done; a new ADD after release completes normally.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// alu_seq_ctrl : command sequencer for an external 16-bit ALU (AND/OR/ADD/SUB, shift-add MUL)
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  cmd,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_sreg
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [3:0] LAST_STEP = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cmd_q;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [3:0]  step;
  logic        lost;
  logic        ovf;
  logic        cmd_legal;
  logic [15:0] acc_nxt;
  logic        ovf_nxt;

  always_comb begin
    cmd_legal = 1'b0;
    case (cmd)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL: cmd_legal = 1'b1;
      default:                               cmd_legal = 1'b0;
    endcase
  end

  // A set multiplier bit overflows if the add carries or a multiplicand bit was already shifted out.
  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf;
    if (mplier[0]) begin
      acc_nxt = alu_result;
      ovf_nxt = ovf | alu_sreg[0] | lost;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_op    = OP_AND;
    alu_a     = 16'd0;
    alu_b     = 16'd0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!cmd_legal)          state_nxt = DONE;
          else if (cmd == OP_MUL)  state_nxt = MUL;
          else                     state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        alu_op    = cmd_q;
        alu_a     = mcand;
        alu_b     = mplier;
        state_nxt = DONE;
      end
      MUL: begin
        busy   = 1'b1;
        alu_op = OP_ADD;
        alu_a  = acc;
        alu_b  = mcand;
        if (step == LAST_STEP) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops reuse mcand/mplier as their latched operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= OP_AND;
      acc    <= 16'd0;
      mcand  <= 16'd0;
      mplier <= 16'd0;
      step   <= 4'd0;
      lost   <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      result <= 16'd0;
      flags  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cmd_legal) begin
              err    <= 1'b0;
              cmd_q  <= cmd;
              acc    <= 16'd0;
              mcand  <= op_a;
              mplier <= op_b;
              step   <= 4'd0;
              lost   <= 1'b0;
              ovf    <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EXEC: begin
          result <= alu_result;
          flags  <= alu_sreg;
        end
        MUL: begin
          acc    <= acc_nxt;
          ovf    <= ovf_nxt;
          lost   <= lost | mcand[15];
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + 4'd1;
          if (step == LAST_STEP) begin
            result <= acc_nxt;
            flags  <= {1'b0, acc_nxt[15], (acc_nxt == 16'd0), ovf_nxt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// tb_alu_seq_ctrl : directed-vector bench with a behavioural model of the external ALU
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  cmd;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic [3:0]  alu_sreg;
  logic [16:0] alu_sum;

  int vectors;
  int miscompares;

  alu_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cmd        (cmd),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .flags      (flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_sreg   (alu_sreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: {V,N,Z,C}; SUB reports borrow in C.
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_sreg   = '0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        alu_sum     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result  = alu_sum[15:0];
        alu_sreg[0] = alu_sum[16];
        alu_sreg[3] = (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
      end
      3'b110: begin
        alu_sum     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result  = alu_sum[15:0];
        alu_sreg[0] = alu_sum[16];
        alu_sreg[3] = (alu_a[15] != alu_b[15]) && (alu_result[15] != alu_a[15]);
      end
      default: ;
    endcase
    alu_sreg[2] = alu_result[15];
    alu_sreg[1] = (alu_result == 16'd0);
  end

  // Called at a falling edge; returns at the falling edge of cycle T+1 with inputs scrambled.
  task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    cmd   = c;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    cmd   = 3'b111;
    op_a  = 16'hDEAD;
    op_b  = 16'hBEEF;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    int cyc;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, err, result, flags, alu_a, alu_b, alu_op} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b result=%h flags=%b alu_a=%h alu_b=%h alu_op=%b, want all zero",
               busy, done, err, result, flags, alu_a, alu_b, alu_op);
    end
    rst_n = 1'b1;
    issue(3'b010, 16'd16, 16'd1);
    vectors++;
    if ({busy, done, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, 3'b010, 16'd16, 16'd1}) begin
      miscompares++;
      $display("FAIL first_start_exec: got busy=%b done=%b alu_op=%b alu_a=%0d alu_b=%0d, want 1 0 010 16 1",
               busy, done, alu_op, alu_a, alu_b);
    end
    wait_done(cyc);
    vectors++;
    if (cyc != 1 || result !== 16'd17 || flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL first_start_done: got cycles=%0d result=%0d flags=%b, want 1 17 0000", cyc, result, flags);
    end
    @(negedge clk);
  endtask

  task automatic test_single_cycle;
    logic [2:0]  tc [6];
    logic [15:0] ta [6];
    logic [15:0] tb [6];
    logic [15:0] tr [6];
    logic [3:0]  tf [6];
    int cyc;
    tc = '{3'b010,  3'b110,  3'b010,   3'b110,  3'b000,   3'b001};
    ta = '{16'd16,  16'd15,  16'hFFFF, 16'd15,  16'hF0F0, 16'hF0F0};
    tb = '{16'd1,   16'd15,  16'd1,    16'd16,  16'h3C3C, 16'h0F00};
    tr = '{16'd17,  16'd0,   16'd0,    16'hFFFF,16'h3030, 16'hFFF0};
    tf = '{4'b0000, 4'b0010, 4'b0011,  4'b0101, 4'b0000,  4'b0100};
    for (int i = 0; i < 6; i++) begin
      issue(tc[i], ta[i], tb[i]);
      wait_done(cyc);
      vectors++;
      if (cyc != 1) begin
        miscompares++;
        $display("FAIL single_latency[%0d]: got done %0d cycles after T+1, want 1", i, cyc);
      end
      vectors++;
      if (result !== tr[i] || flags !== tf[i]) begin
        miscompares++;
        $display("FAIL single_result[%0d]: got result=%h flags=%b, want %h %b", i, result, flags, tr[i], tf[i]);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'hFFF0 || flags !== 4'b0100) begin
      miscompares++;
      $display("FAIL hold_between: got done=%b busy=%b result=%h flags=%b, want 0 0 fff0 0100", done, busy, result, flags);
    end
  endtask

  task automatic test_mul;
    logic [15:0] ta [7];
    logic [15:0] tb [7];
    logic [15:0] tr [7];
    logic [3:0]  tf [7];
    int cyc;
    ta = '{16'd300,  16'd256, 16'hFFFF, 16'd0,   16'h8000, 16'd300,  16'h6000};
    tb = '{16'd200,  16'd256, 16'd1,    16'd5,   16'd3,    16'd300,  16'd3};
    tr = '{16'hEA60, 16'd0,   16'hFFFF, 16'd0,   16'h8000, 16'h5F90, 16'h2000};
    tf = '{4'b0100,  4'b0011, 4'b0100,  4'b0010, 4'b0101,  4'b0001,  4'b0001};
    for (int i = 0; i < 7; i++) begin
      issue(3'b011, ta[i], tb[i]);
      vectors++;
      if ({busy, alu_op, alu_a, alu_b} !== {1'b1, 3'b010, 16'd0, ta[i]}) begin
        miscompares++;
        $display("FAIL mul_first_step[%0d]: got busy=%b alu_op=%b alu_a=%h alu_b=%h, want 1 010 0000 %h",
                 i, busy, alu_op, alu_a, alu_b, ta[i]);
      end
      wait_done(cyc);
      vectors++;
      if (cyc != 16) begin
        miscompares++;
        $display("FAIL mul_latency[%0d]: got done %0d cycles after T+1, want 16", i, cyc);
      end
      vectors++;
      if (result !== tr[i] || flags !== tf[i] || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_result[%0d]: got result=%h flags=%b busy=%b, want %h %b 0", i, result, flags, busy, tr[i], tf[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal;
    logic [2:0] bad [2];
    int cyc;
    bad = '{3'b111, 3'b100};
    for (int i = 0; i < 2; i++) begin
      issue(bad[i], 16'd1, 16'd1);
      vectors++;
      if ({done, busy, err, result, flags} !== {1'b1, 1'b0, 1'b1, 16'h2000, 4'b0001}) begin
        miscompares++;
        $display("FAIL illegal_done[%0d]: got done=%b busy=%b err=%b result=%h flags=%b, want 1 0 1 2000 0001",
                 i, done, busy, err, result, flags);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || err !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal_hold[%0d]: got done=%b err=%b, want 0 1", i, done, err);
      end
    end
    issue(3'b000, 16'hFFFF, 16'h00FF);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: got err=%b busy=%b, want 0 1", err, busy);
    end
    wait_done(cyc);
    vectors++;
    if (cyc != 1 || result !== 16'h00FF || flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL after_illegal: got cycles=%0d result=%h flags=%b, want 1 00ff 0000", cyc, result, flags);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    int n_done;
    int n_busy;
    issue(3'b011, 16'd300, 16'd200);
    repeat (2) @(negedge clk);
    start = 1'b1;
    cmd   = 3'b010;
    op_a  = 16'd1;
    op_b  = 16'd1;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    vectors++;
    if (n_done != 1 || result !== 16'hEA60) begin
      miscompares++;
      $display("FAIL start_while_busy: got %0d done pulses result=%h, want 1 ea60", n_done, result);
    end
    issue(3'b010, 16'd2, 16'd3);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || result !== 16'd5) begin
      miscompares++;
      $display("FAIL add_before_done_start: got done=%b result=%0d, want 1 5", done, result);
    end
    start = 1'b1;
    cmd   = 3'b010;
    op_a  = 16'd100;
    op_b  = 16'd100;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) n_done++;
      if (busy) n_busy++;
      @(negedge clk);
    end
    vectors++;
    if (n_done != 0 || n_busy != 0 || result !== 16'd5) begin
      miscompares++;
      $display("FAIL start_in_done: got %0d done, %0d busy cycles, result=%0d, want 0 0 5", n_done, n_busy, result);
    end
  endtask

  task automatic test_reset_mid_mul;
    int n_done;
    int cyc;
    issue(3'b011, 16'd300, 16'd200);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, result, flags, alu_a, alu_b, alu_op} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_mul: got busy=%b done=%b err=%b result=%h flags=%b alu_a=%h alu_b=%h alu_op=%b, want all zero",
               busy, done, err, result, flags, alu_a, alu_b, alu_op);
    end
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    vectors++;
    if (n_done != 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d done pulses, want 0", n_done);
    end
    issue(3'b010, 16'd2, 16'd3);
    wait_done(cyc);
    vectors++;
    if (cyc != 1 || result !== 16'd5 || flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL add_after_reset: got cycles=%0d result=%0d flags=%b, want 1 5 0000", cyc, result, flags);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    cmd         = 3'b000;
    op_a        = 16'd0;
    op_b        = 16'd0;
    test_reset;
    test_single_cycle;
    test_mul;
    test_illegal;
    test_ignore;
    test_reset_mid_mul;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
